// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start(0), DATA_W bits LSB first, optional even parity, stop(1).
// Parity stage is built only when SERIAL_FRAME_TX_PARITY_EN is defined.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              ret,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              tx_n,
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int IDX_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_next;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_next;
  logic                r_tx;
  logic                r_tx_n;
  logic                w_tx_next;
  logic                w_cnt_last;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic                r_parity;
  logic                w_parity_next;
`endif

  always_ff @(posedge clk or negedge ret) begin
    if (!ret) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_tx_n   <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_idx    <= w_idx_next;
      r_shift  <= w_shift_next;
      r_tx     <= w_tx_next;
      r_tx_n   <= ~w_tx_next;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  // Line value is derived from the current state and registered, so tx trails state by one clk.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_tx_next    = 1'b1;
    w_cnt_last   = (r_cnt == CNT_LAST);
`ifdef SERIAL_FRAME_TX_PARITY_EN
    w_parity_next = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (in_valid) begin
          w_shift_next = in_data;
          w_state_next = S_START;
          w_cnt_next   = '0;
          w_idx_next   = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          w_parity_next = ^in_data;
`endif
        end
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_cnt_last) begin
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_state_next = S_DATA;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        w_tx_next = r_shift[0];
        if (w_cnt_last) begin
          w_cnt_next   = '0;
          w_shift_next = r_shift >> 1;
          if (r_idx == IDX_LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY: begin
        w_tx_next = r_parity;
        if (w_cnt_last) begin
          w_cnt_next   = '0;
          w_state_next = S_STOP;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        w_tx_next = 1'b1;
        if (w_cnt_last) begin
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_idx_next   = '0;
      end
    endcase
  end

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign tx       = r_tx;
  assign tx_n     = r_tx_n;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: frames are compared against a bit-list model built from the word.
// Parity expectations follow SERIAL_FRAME_TX_PARITY_EN, matching the RTL build.
module tb_serial_frame_tx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          ret = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          v0 = 1'b0;
  logic          v1 = 1'b0;
  logic          sel = 1'b0;
  logic          rdy0, tx0, txn0, busy0;
  logic          rdy1, tx1, txn1, busy1;
  logic          m_tx, m_txn, m_rdy, m_busy;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .ret(ret), .in_data(in_data), .in_valid(v0),
    .in_ready(rdy0), .tx(tx0), .tx_n(txn0), .busy(busy0)
  );

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .ret(ret), .in_data(in_data), .in_valid(v1),
    .in_ready(rdy1), .tx(tx1), .tx_n(txn1), .busy(busy1)
  );

  always #5 clk = ~clk;

  assign m_tx   = sel ? tx1   : tx0;
  assign m_txn  = sel ? txn1  : txn0;
  assign m_rdy  = sel ? rdy1  : rdy0;
  assign m_busy = sel ? busy1 : busy0;

  // Line image of one frame, one entry per clk.
  task automatic build_exp(input logic [DW-1:0] w, input int cpb);
    bit frame[$];
    frame.push_back(1'b0);
    for (int i = 0; i < DW; i++) frame.push_back(w[i]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
    frame.push_back(^w);
`endif
    frame.push_back(1'b1);
    exp_q = {};
    foreach (frame[j]) repeat (cpb) exp_q.push_back(frame[j]);
  endtask

  task automatic start_frame(input logic [DW-1:0] w, input string name);
    int n = 0;
    @(negedge clk);
    in_data = w;
    if (sel) v1 = 1'b1; else v0 = 1'b1;
    while (!m_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m_rdy !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_timeout in_ready=%b expected=1", name, m_rdy);
    end
    @(posedge clk);
  endtask

  // Called right after the accepting posedge.
  task automatic check_frame(input logic [DW-1:0] w, input int cpb, input string name,
                             input bit hold, input logic [DW-1:0] nxt);
    int n;
    build_exp(w, cpb);
    n = exp_q.size();
    @(negedge clk);
    checks++;
    if (m_tx !== 1'b1 || m_rdy !== 1'b0) begin
      failures++;
      $display("FAIL %s latency tx=%b in_ready=%b expected tx=1 in_ready=0", name, m_tx, m_rdy);
    end
    if (hold) in_data = nxt;
    else begin
      in_data = DW'($urandom);
      v0 = 1'b0;
      v1 = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if (m_tx !== exp_q[k]) begin
        failures++;
        $display("FAIL %s tx k=%0d tx=%b expected=%b", name, k, m_tx, exp_q[k]);
      end
      checks++;
      if (m_txn !== !exp_q[k]) begin
        failures++;
        $display("FAIL %s tx_n k=%0d tx_n=%b expected=%b", name, k, m_txn, !exp_q[k]);
      end
      checks++;
      if (m_rdy !== (k == n - 1) || m_busy !== (k != n - 1)) begin
        failures++;
        $display("FAIL %s ready_busy k=%0d in_ready=%b busy=%b expected in_ready=%b busy=%b",
                 name, k, m_rdy, m_busy, (k == n - 1), (k != n - 1));
      end
    end
  endtask

  task automatic test_reset();
    ret = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v0 = i[0];
      v1 = ~i[0];
      in_data = DW'($urandom);
      checks++;
      if (tx0 !== 1'b1 || txn0 !== 1'b0 || busy0 !== 1'b0 || rdy0 !== 1'b1 ||
          tx1 !== 1'b1 || txn1 !== 1'b0 || busy1 !== 1'b0 || rdy1 !== 1'b1) begin
        failures++;
        $display("FAIL reset i=%0d tx=%b%b tx_n=%b%b busy=%b%b in_ready=%b%b expected 11 00 00 11",
                 i, tx0, tx1, txn0, txn1, busy0, busy1, rdy0, rdy1);
      end
    end
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
    ret = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || rdy0 !== 1'b1 || tx1 !== 1'b1 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release tx=%b%b busy=%b%b in_ready=%b expected tx=11 busy=00 in_ready=1",
               tx0, tx1, busy0, busy1, rdy0);
    end
  endtask

  task automatic test_single();
    sel = 1'b0;
    start_frame(8'hA5, "single_a5");
    check_frame(8'hA5, 4, "single_a5", 1'b0, '0);
  endtask

  task automatic test_parity_words();
    sel = 1'b0;
    start_frame(8'h07, "word_07");
    check_frame(8'h07, 4, "word_07", 1'b0, '0);
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = DW'($urandom);
      start_frame(w, "random");
      check_frame(w, 4, "random", 1'b0, '0);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    start_frame(8'h00, "b2b_00");
    check_frame(8'h00, 4, "b2b_00", 1'b1, 8'hFF);
    @(posedge clk);
    check_frame(8'hFF, 4, "b2b_ff", 1'b0, '0);
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    build_exp(8'h5A, 4);
    start_frame(8'h5A, "mid_reset");
    @(negedge clk);
    v0 = 1'b0;
    for (int k = 0; k < 18; k++) @(negedge clk);
    checks++;
    if (tx0 !== exp_q[17] || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_pre tx=%b busy=%b expected tx=%b busy=1", tx0, busy0, exp_q[17]);
    end
    #1 ret = 1'b0;
    #1;
    checks++;
    if (tx0 !== 1'b1 || txn0 !== 1'b0 || busy0 !== 1'b0 || rdy0 !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_async tx=%b tx_n=%b busy=%b in_ready=%b expected 1 0 0 1",
               tx0, txn0, busy0, rdy0);
    end
    @(negedge clk);
    ret = 1'b1;
    start_frame(8'h3C, "after_reset_3c");
    check_frame(8'h3C, 4, "after_reset_3c", 1'b0, '0);
  endtask

  task automatic test_cpb1();
    logic [DW-1:0] w;
    sel = 1'b1;
    start_frame(8'h81, "cpb1_81");
    check_frame(8'h81, 1, "cpb1_81", 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      w = DW'($urandom);
      start_frame(w, "cpb1_random");
      check_frame(w, 1, "cpb1_random", 1'b0, '0);
    end
    sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_parity_words();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_cpb1();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter; drives the single-bit serial line that our D-flip-flop receiver stages sample on clk.
- Accepts a DATA_W-bit word over a valid/ready handshake.
- Emits start bit (0), data LSB first, optional parity, then stop bit (1). Each bit is held CLKS_PER_BIT clocks.
- Provides true and complement line outputs, matching the q/~q pairing used by the receiver flops.

Parameters:
- DATA_W, 8, payload bits per frame (1..32).
- CLKS_PER_BIT, 4, clk cycles each serial bit is held (>=1).

Ports:
- clk  input  1  system clock, all logic on posedge.
- ret  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  word to transmit.
- in_valid  input  1  in_data valid.
- in_ready  output  1  transmitter can accept a word.
- tx  output  1  serial line, idle high.
- tx_n  output  1  always ~tx.
- busy  output  1  frame in progress.

Behaviour:
- Reset: ret low forces the following immediately, without waiting for clk:
  - tx=1, tx_n=0, busy=0, in_ready=1.
  - state=IDLE; bit and cycle counters cleared; shift register cleared.
- Reset mid-frame: the frame is aborted, tx returns to 1 at once, and the in-flight word is discarded.
- Sequential logic: ret in the sensitivity list with negedge, clk with posedge.
- Outputs: tx and tx_n are registered; tx_n is a separate register updated with tx, never a combinational invert.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE:
  - in_ready=1, busy=0, tx=1.
  - On posedge with in_valid&&in_ready: latch in_data into the shift register, go to START, clear cycle counter.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift_reg[0] for CLKS_PER_BIT cycles, then shift right and increment bit index.
  - After bit DATA_W-1, go to PARITY (macro defined) or STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: tx falls on the first posedge after the accepting posedge, i.e. one clock after the handshake.
- Frame length: CLKS_PER_BIT*(DATA_W+2) cycles, plus CLKS_PER_BIT when parity is enabled.
- in_ready:
  - in_ready = (state==IDLE), registered/decoded from state only.
  - in_ready returns to 1 the cycle after the last STOP cycle.
  - Back-to-back frames therefore have 1 idle clk between STOP and the next START, minimum.
- busy = (state!=IDLE).
- Input handling: in_valid while not ready is ignored (no buffering); the sender must hold in_valid until it sees in_ready.
- in_data changes after acceptance have no effect on the current frame.
- Cycle counter: width clog2(CLKS_PER_BIT)+1, wraps to 0 at CLKS_PER_BIT-1.
- CLKS_PER_BIT=1: one bit per clk, no idle cycles inside a frame.
- ret deasserting on a clk edge: first valid accept is the following posedge.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined: PARITY state inserted after DATA; tx = even parity (XOR of all latched data bits) held CLKS_PER_BIT cycles. The parity value is computed at accept time from in_data.
- Undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Test Plan:
- Reset: hold ret=0 with in_valid=1 toggling -> tx=1, tx_n=0, busy=0, in_ready=1 throughout; no frame starts.
- Single frame: DATA_W=8, CLKS_PER_BIT=4, no macro, send 0xA5 -> tx holds each of 0,1,0,1,0,0,1,0,1,1 for 4 clks.
  - Total 40 clks; tx_n is the exact complement every cycle.
  - in_ready=0 for those 40 clks.
- Parity: macro defined, send 0xA5 -> parity bit 0 after data. Send 0x07 -> parity bit 1. Frame = 44 clks.
- Back-to-back: in_valid held high with 0x00 then 0xFF -> second start bit begins exactly 1 clk after first stop ends.
  - The 0x00 data bits are all 0; the 0xFF data bits are all 1.
- Mid-frame reset: pull ret low asynchronously during data bit 3 of 0x5A -> tx=1 before the next posedge.
  - After release, the next accepted word 0x3C transmits cleanly with no residue of 0x5A.
- CLKS_PER_BIT=1, send 0x81 -> tx = 0,1,0,0,0,0,0,0,1,1 on consecutive clks.
